// File: rtl/cal_pkg.sv
// Shared types and constants for the channel calibration stage.
package cal_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int N_SLOTS   = 8;
    localparam int IDX_W     = $clog2(N_SLOTS);
    localparam int GAIN_FRAC = SAMPLE_W - 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t GAIN_UNITY = sample_t'(1 << GAIN_FRAC);

    typedef struct packed {
        sample_t offset;
        sample_t gain;
    } coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        PUBLISH
    } state_e;

    function automatic coeff_t unity_coeff();
        coeff_t c;
        c.offset = '0;
        c.gain   = GAIN_UNITY;
        return c;
    endfunction

endpackage

// File: rtl/cal_datapath.sv
// Three-stage offset/gain pipeline: offset add, multiply, floor-shift and saturate.
// A valid bit and slot index travel with each sample.
module cal_datapath
    import cal_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    vld_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic signed [W-1:0]     x_i,
    input  coeff_t                  coeff_i,
    output logic                    vld_o,
    output logic [IDX_W-1:0]        idx_o,
    output logic signed [W-1:0]     y_o,
    output logic                    pipe_busy_o
);

    function automatic logic signed [2*W:0] floor_shift(input logic signed [2*W:0] v);
        return v >>> GAIN_FRAC;
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [2*W:0] v);
        logic signed [2*W:0] hi;
        logic signed [2*W:0] lo;
        hi = {{(W+2){1'b0}}, {(W-1){1'b1}}};
        lo = {{(W+2){1'b1}}, {(W-1){1'b0}}};
        if (v > hi) begin
            return hi[W-1:0];
        end else if (v < lo) begin
            return lo[W-1:0];
        end
        return v[W-1:0];
    endfunction

    logic                   vld_p0;
    logic                   vld_p1;
    logic [IDX_W-1:0]       idx_p0;
    logic [IDX_W-1:0]       idx_p1;
    logic signed [W:0]      sum_p0;
    logic signed [W-1:0]    gain_p0;
    logic signed [2*W:0]    prod_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= vld_i;
            vld_p1 <= vld_p0;
        end
    end

    // S1: offset add (W+1 bits, cannot overflow)
    always_ff @(posedge clk_i) begin
        if (vld_i) begin
            idx_p0  <= idx_i;
            sum_p0  <= $signed({x_i[W-1], x_i}) + $signed({coeff_i.offset[W-1], coeff_i.offset});
            gain_p0 <= coeff_i.gain;
        end
    end

    // S2: multiply (2W+1 bits)
    always_ff @(posedge clk_i) begin
        if (vld_p0) begin
            idx_p1  <= idx_p0;
            prod_p1 <= $signed({{W{sum_p0[W]}}, sum_p0}) * $signed({{(W+1){gain_p0[W-1]}}, gain_p0});
        end
    end

    // S3: shift and saturate, registered by the caller's staging array
    assign vld_o       = vld_p1;
    assign idx_o       = idx_p1;
    assign y_o         = sat_w(floor_shift(prod_p1));
    assign pipe_busy_o = vld_p0 | vld_p1;

endmodule

// File: rtl/channel_cal.sv
// Per-slot offset/gain calibration over 8 time-multiplexed sample slots,
// with double-buffered coefficients and frame-synchronous output publish.
module channel_cal
    import cal_pkg::*;
#(
    parameter int W       = SAMPLE_W,
    parameter int N_SLOTS = cal_pkg::N_SLOTS
) (
    input  logic                    clk_256fs,
    input  logic                    rst,
    input  logic                    strobe,
    input  logic [N_SLOTS*W-1:0]    sample_in,
    output logic [N_SLOTS*W-1:0]    sample_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    cal_wr_en,
    input  logic [IDX_W-1:0]        cal_wr_addr,
    input  logic signed [W-1:0]     cal_wr_offset,
    input  logic signed [W-1:0]     cal_wr_gain
);

    state_e                 state_q;
    state_e                 state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic                   overrun_q;

    logic                   accept;
    logic                   issue;
    logic                   publish_load;

    coeff_t                 pend_q [N_SLOTS];
    coeff_t                 pend_d [N_SLOTS];
    coeff_t                 act_q  [N_SLOTS];

    logic [N_SLOTS*W-1:0]   in_q;
    logic [N_SLOTS*W-1:0]   sample_out_q;
    logic signed [W-1:0]    stage_q [N_SLOTS];

    logic signed [W-1:0]    issue_x;
    logic                   dp_vld;
    logic [IDX_W-1:0]       dp_idx;
    logic signed [W-1:0]    dp_y;
    logic                   pipe_busy;

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (strobe && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_SLOTS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept       = (state_q == IDLE) && strobe;
        issue        = (state_q == RUN);
        publish_load = (state_q == DRAIN) && !pipe_busy;
        busy         = (state_q != IDLE);
        out_valid    = (state_q == PUBLISH);
    end

    // A write coincident with an accepted strobe is forwarded into the commit.
    always_comb begin
        pend_d = pend_q;
        if (cal_wr_en) begin
            pend_d[cal_wr_addr].offset = cal_wr_offset;
            pend_d[cal_wr_addr].gain   = cal_wr_gain;
        end
    end

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                pend_q[k] <= unity_coeff();
                act_q[k]  <= unity_coeff();
            end
        end else begin
            pend_q <= pend_d;
            if (accept) begin
                act_q <= pend_d;
            end
        end
    end

    always_ff @(posedge clk_256fs) begin
        if (accept) begin
            in_q <= sample_in;
        end
        if (dp_vld) begin
            stage_q[dp_idx] <= dp_y;
        end
    end

    always_ff @(posedge clk_256fs or posedge rst) begin
        if (rst) begin
            sample_out_q <= '0;
        end else if (publish_load) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                sample_out_q[k*W +: W] <= stage_q[k];
            end
        end
    end

    assign issue_x    = in_q[int'(idx_q)*W +: W];
    assign sample_out = sample_out_q;
    assign overrun    = overrun_q;

    cal_datapath #(
        .W (W)
    ) u_datapath (
        .clk_i       (clk_256fs),
        .rst_i       (rst),
        .vld_i       (issue),
        .idx_i       (idx_q),
        .x_i         (issue_x),
        .coeff_i     (act_q[idx_q]),
        .vld_o       (dp_vld),
        .idx_o       (dp_idx),
        .y_o         (dp_y),
        .pipe_busy_o (pipe_busy)
    );

endmodule

// File: tb/tb_channel_cal.sv
// Randomized self-checking bench for channel_cal against an arithmetic reference model.
module tb_channel_cal;

    logic           clk_256fs = 1'b0;
    logic           rst;
    logic           strobe;
    logic [127:0]   sample_in;
    logic [127:0]   sample_out;
    logic           out_valid;
    logic           busy;
    logic           overrun;
    logic           cal_wr_en;
    logic [2:0]     cal_wr_addr;
    logic signed [15:0] cal_wr_offset;
    logic signed [15:0] cal_wr_gain;

    int n_chk = 0;
    int n_err = 0;

    int pend_off [8];
    int pend_g   [8];
    int act_off  [8];
    int act_g    [8];
    int xs       [8];
    int exp_y    [8];
    bit exp_ovr;

    always #5 clk_256fs = ~clk_256fs;

    channel_cal dut (
        .clk_256fs     (clk_256fs),
        .rst           (rst),
        .strobe        (strobe),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun),
        .cal_wr_en     (cal_wr_en),
        .cal_wr_addr   (cal_wr_addr),
        .cal_wr_offset (cal_wr_offset),
        .cal_wr_gain   (cal_wr_gain)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // y = clamp(floor((x + off) * g / 2^14))
    function automatic int cal_ref(input int x, input int off, input int g);
        longint p;
        longint q;
        p = longint'(x + off) * longint'(g);
        if (p >= 0) q = p / 16384;
        else        q = -((-p + 16383) / 16384);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    function automatic int rand16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            pend_off[k] = 0; pend_g[k] = 16384;
            act_off[k]  = 0; act_g[k]  = 16384;
        end
        exp_ovr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_256fs);
        #1;
    endtask

    task automatic wr_coef(input int a, input int o, input int g);
        cal_wr_en     = 1'b1;
        cal_wr_addr   = 3'(a);
        cal_wr_offset = 16'(o);
        cal_wr_gain   = 16'(g);
        pend_off[a] = o;
        pend_g[a]   = g;
        tick();
        cal_wr_en = 1'b0;
    endtask

    // Runs one 21-cycle frame window; cycle 0 carries the strobe.
    task automatic do_frame(input int wr_cyc, input int wr_a, input int wr_o, input int wr_g,
                            input int dup_cyc, input int rst_cyc, input string name);
        int first_vld;
        int nvld;
        bit aborted;
        first_vld = -1;
        nvld      = 0;
        aborted   = 1'b0;
        for (int k = 0; k < 8; k++) sample_in[k*16 +: 16] = 16'(xs[k]);
        for (int c = 0; c <= 20; c++) begin
            if (out_valid) begin
                nvld++;
                if (first_vld < 0) first_vld = c;
            end
            if (rst_cyc < 0 && (c == 0 || c == 1 || c == 12 || c == 13))
                chk($sformatf("%s/busy@%0d", name, c), int'(busy), (c >= 1 && c <= 12) ? 1 : 0);
            strobe = (c == 0 || c == dup_cyc);
            if (c == wr_cyc) begin
                cal_wr_en     = 1'b1;
                cal_wr_addr   = 3'(wr_a);
                cal_wr_offset = 16'(wr_o);
                cal_wr_gain   = 16'(wr_g);
                pend_off[wr_a] = wr_o;
                pend_g[wr_a]   = wr_g;
            end else begin
                cal_wr_en = 1'b0;
            end
            if (c == 0) begin
                for (int k = 0; k < 8; k++) begin
                    act_off[k] = pend_off[k];
                    act_g[k]   = pend_g[k];
                    exp_y[k]   = cal_ref(xs[k], act_off[k], act_g[k]);
                end
            end
            if (c == dup_cyc) exp_ovr = 1'b1;
            if (c == rst_cyc) begin
                rst = 1'b1;
                model_reset();
                aborted = 1'b1;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        strobe    = 1'b0;
        cal_wr_en = 1'b0;
        rst       = 1'b0;
        if (aborted) begin
            chk({name, "/nvld"}, nvld, 0);
            chk({name, "/busy"}, int'(busy), 0);
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s/y%0d", name, k), int'($signed(sample_out[k*16 +: 16])), 0);
        end else begin
            chk({name, "/lat"}, first_vld, 12);
            chk({name, "/nvld"}, nvld, 1);
            for (int k = 0; k < 8; k++)
                chk($sformatf("%s/y%0d", name, k), int'($signed(sample_out[k*16 +: 16])), exp_y[k]);
        end
        chk({name, "/ovr"}, int'(overrun), int'(exp_ovr));
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) xs[k] = 1000 * k - 3000;
    endtask

    initial begin
        rst           = 1'b1;
        strobe        = 1'b0;
        sample_in     = '0;
        cal_wr_en     = 1'b0;
        cal_wr_addr   = '0;
        cal_wr_offset = '0;
        cal_wr_gain   = '0;
        model_reset();
        repeat (3) tick();
        chk("rst/out", int'(sample_out != 0), 0);
        chk("rst/vld", int'(out_valid), 0);
        chk("rst/busy", int'(busy), 0);
        chk("rst/ovr", int'(overrun), 0);
        rst = 1'b0;
        tick();

        set_ramp();
        do_frame(-1, 0, 0, 0, -1, -1, "ident");

        wr_coef(2, -100, 8192);
        set_ramp();
        xs[2] = 1100;
        do_frame(-1, 0, 0, 0, -1, -1, "gainoff");

        wr_coef(0, 0, 32767);
        wr_coef(1, 0, 32767);
        wr_coef(3, 0, 16384);
        wr_coef(4, 0, 8192);
        set_ramp();
        xs[0] = 30000; xs[1] = -30000; xs[3] = -1; xs[4] = -1;
        do_frame(-1, 0, 0, 0, -1, -1, "sat");

        set_ramp();
        xs[5] = 2000;
        do_frame(0, 5, 0, 8192, -1, -1, "race0");
        xs[6] = 3000;
        do_frame(4, 6, 10, -16384, -1, -1, "raceRun");
        do_frame(-1, 0, 0, 0, -1, -1, "raceNext");

        for (int r = 0; r < 6; r++) begin
            wr_coef($urandom_range(0, 7), rand16(), rand16());
            for (int k = 0; k < 8; k++) xs[k] = rand16();
            do_frame($urandom_range(0, 14), $urandom_range(0, 7), rand16(), rand16(), -1, -1,
                     $sformatf("rnd%0d", r));
        end

        for (int k = 0; k < 8; k++) xs[k] = rand16();
        do_frame(-1, 0, 0, 0, 5, -1, "ovr5");

        set_ramp();
        do_frame(-1, 0, 0, 0, -1, 6, "rstmid");
        do_frame(-1, 0, 0, 0, -1, -1, "postrst");

        for (int k = 0; k < 8; k++) xs[k] = rand16();
        do_frame(-1, 0, 0, 0, 12, -1, "ovrPub");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/channel_cal.md
# channel_cal

Per-channel offset/gain calibration stage that sits on the sample side of the AK4619 CODEC driver. Time-multiplexes one multiplier over 8 sample slots:
- slots 0-3: raw ADC samples from the driver, going to the DSP core;
- slots 4-7: DSP samples, going to the driver's DAC inputs.

It runs once per sample strobe and publishes all calibrated outputs together. Coefficients are double-buffered, so a write never tears a frame.

## Interface
Parameters:
- W, 16, sample width in bits (signed).
- N_SLOTS, 8, number of calibrated slots; fixed at 8 for this revision.

Ports:
- clk_256fs  in  1  sample-domain clock (256·Fs).
- rst  in  1  asynchronous, active-high reset.
- strobe  in  1  one-cycle frame pulse, same strobe as the CODEC driver.
- sample_in  in  N_SLOTS×W  uncalibrated samples; slot k occupies bits [k·W +: W].
- sample_out  out  N_SLOTS×W  calibrated samples, same packing.
- out_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high while a frame is in flight.
- overrun  out  1  sticky; set when a strobe arrives while busy; cleared only by rst.
- cal_wr_en  in  1  coefficient write enable.
- cal_wr_addr  in  3  target slot.
- cal_wr_offset  in  W  signed offset.
- cal_wr_gain  in  W  signed gain, Q2.(W-2); 1.0 = 2^(W-2) = 16384 for W=16.

## Operation
- Transfer function, per slot k: y = sat_W(((x + off_k) · gain_k) >>> (W-2)).
  - The sum x + off_k is W+1 bits and never overflows.
  - The product is 2W+1 bits.
  - The shift is arithmetic, rounding toward −∞.
  - Saturation clamps to the range [−2^(W-1), 2^(W-1)−1].
- Coefficient banks:
  - Writes land in the pending bank on any cycle, with no back-pressure.
  - On an accepted strobe, the pending bank is copied to the active bank.
  - A write in the same cycle as the strobe is included in that copy (forwarded).
  - The datapath reads only the active bank.
- FSM states:
  - IDLE: on strobe, latch sample_in into the input register, commit the coefficients, go to RUN with idx=0.
  - RUN: issue slot idx into the pipeline and increment idx. After issuing idx=7, go to DRAIN.
  - DRAIN: wait for the pipeline to empty, then go to PUBLISH.
  - PUBLISH: copy the staging register to sample_out, pulse out_valid, return to IDLE.
- Overrun handling:
  - A strobe seen in any state other than IDLE is ignored.
  - It sets overrun; the frame in flight completes unaffected.
  - A strobe in the PUBLISH cycle also counts as overrun.
- Reset values:
  - sample_out = 0, out_valid = 0, busy = 0, overrun = 0.
  - FSM in IDLE; idx = 0; pipeline valid bits cleared.
  - Both coefficient banks set to offset 0, gain 2^(W-2) (identity).
- Reset asserted mid-frame aborts the frame immediately. No out_valid is emitted for it.

## Timing
- Strobe accepted in cycle 0.
- Slot k is issued in cycle k+1. Pipeline stages:
  - S1 (offset add): cycle k+2.
  - S2 (multiply): cycle k+3.
  - S3 (shift and saturate, written to staging): cycle k+4.
- Slot 7 reaches staging in cycle 11. sample_out updates and out_valid is high in cycle 12.
- Fixed latency: 12 cycles from strobe to out_valid.
- busy is high for cycles 1-12 inclusive.
- Minimum strobe spacing is 13 cycles; the normal spacing of 256 leaves ample margin.
- sample_out holds its value between out_valid pulses.

## Structure
- Shared package cal_pkg, containing:
  - N_SLOTS;
  - GAIN_FRAC = W-2;
  - GAIN_UNITY;
  - the FSM state enum (IDLE, RUN, DRAIN, PUBLISH);
  - a sample_t typedef;
  - a coeff_t struct {offset, gain}.
- Sub-module cal_datapath: the 3-stage pipeline, with a valid/idx tag travelling alongside the data.
- The top level holds the FSM, the coefficient banks, the input latch and the staging/output registers.

## Test plan
- Reset defaults: after reset, strobe with slot k = 1000·k − 3000. Expect sample_out equal to the input on every slot (identity), and out_valid exactly 12 cycles after strobe.
- Gain/offset: write slot 2 with offset −100, gain 8192 (0.5); slot 2 input 1100. Expect slot 2 output 500 on the following frame; other slots unchanged.
- Saturation and rounding:
  - gain 32767 (≈2.0), input 30000 → 32767.
  - input −30000 → −32768.
  - gain 16384, offset 0, input −1 → −1; with gain 8192, input −1 → −1 (floor).
- Write race:
  - A write in the strobe cycle takes effect in that frame.
  - A write during RUN takes effect only in the next frame; the current frame's outputs match the old coefficients.
- Overrun: a second strobe 5 cycles after the first → overrun = 1, a single out_valid at cycle 12, output equal to the first frame's inputs.
- Reset mid-frame: assert rst at cycle 6. Expect no out_valid, all outputs 0, coefficients back to identity, and a clean frame on the next strobe.
